// File: rtl/freq_report.sv
// Turns a (fx, gate) count pair into freq = round(fx * CLK_HZ / gate) and streams
// the ASCII line "F=<digits>Hz\r\n" to a UART transmitter over valid/ready.
module freq_report #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] read_fx_cnt,
    input  logic [31:0] read_gate_cnt,
    input  logic        read_over,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] freq_hz,
    output logic        freq_valid,
    output logic        busy
);

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StBcd, StSend} state_e;

    state_e      state_q, state_d;
    logic        ro_q;
    logic        trigger;
    logic [31:0] fx_q, fx_d;
    logic [31:0] gate_q, gate_d;
    logic [63:0] dvd_q, dvd_d;      // dividend, refilled with quotient bits from the LSB
    logic [32:0] rem_q, rem_d;
    logic [32:0] rem_sh;
    logic [6:0]  cnt_q, cnt_d;
    logic [31:0] freq_q, freq_d;
    logic [31:0] bin_q, bin_d;
    logic [39:0] bcd_q, bcd_d;
    logic [39:0] bcd_adj;
    logic [4:0]  ptr_q, ptr_d;
    logic [3:0]  digit [10];
    logic [3:0]  ndig;
    logic [3:0]  didx;
    logic [1:0]  tail_idx;
    logic [7:0]  cur_byte;
    logic        div_done;
    logic        bcd_done;
    logic        last_byte;

    assign trigger   = read_over & ~ro_q;
    assign div_done  = (cnt_q == 7'd64);
    assign bcd_done  = (cnt_q == 7'd32);
    assign last_byte = (ptr_q == 5'(ndig) + 5'd5);
    assign freq_hz   = freq_q;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (trigger) state_d = StMul;
            StMul:  state_d = StDiv;
            StDiv:  if (div_done) state_d = StBcd;
            StBcd:  if (bcd_done) state_d = StSend;
            StSend: if (tx_ready && last_byte) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy       = (state_q != StIdle);
        freq_valid = (state_q == StBcd) && (cnt_q == 7'd0);
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        if (state_q == StSend) begin
            tx_valid = 1'b1;
            tx_data  = cur_byte;
        end
    end

    // Digit extraction and significant-digit count (at least one digit)
    always_comb begin
        ndig = 4'd1;
        for (int i = 0; i < 10; i++) begin
            digit[i] = bcd_q[4*i +: 4];
            if (digit[i] != 4'd0) ndig = 4'(i + 1);
        end
    end

    // Frame byte at position ptr_q: "F=", digits MSB first, "Hz\r\n"
    always_comb begin
        didx     = 4'(5'(ndig) + 5'd1 - ptr_q);
        tail_idx = 2'(ptr_q - 5'd2 - 5'(ndig));
        if (ptr_q == 5'd0) begin
            cur_byte = 8'h46;
        end else if (ptr_q == 5'd1) begin
            cur_byte = 8'h3D;
        end else if (ptr_q < 5'(ndig) + 5'd2) begin
            cur_byte = 8'h30 + {4'h0, digit[didx]};
        end else begin
            case (tail_idx)
                2'd0:    cur_byte = 8'h48;
                2'd1:    cur_byte = 8'h7A;
                2'd2:    cur_byte = 8'h0D;
                default: cur_byte = 8'h0A;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 10; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                          : bcd_q[4*i +: 4];
        end
    end

    assign rem_sh = {rem_q[31:0], dvd_q[63]};

    // Datapath next state
    always_comb begin
        fx_d   = fx_q;
        gate_d = gate_q;
        dvd_d  = dvd_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        freq_d = freq_q;
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        ptr_d  = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    fx_d   = read_fx_cnt;
                    gate_d = read_gate_cnt;
                end
            end
            StMul: begin
                // gate/2 added up front gives round-half-up
                dvd_d = 64'(fx_q) * 64'(CLK_HZ) + 64'(gate_q >> 1);
                rem_d = 33'd0;
                cnt_d = 7'd0;
            end
            StDiv: begin
                if (!div_done) begin
                    if (rem_sh >= {1'b0, gate_q}) begin
                        rem_d = rem_sh - {1'b0, gate_q};
                        dvd_d = {dvd_q[62:0], 1'b1};
                    end else begin
                        rem_d = rem_sh;
                        dvd_d = {dvd_q[62:0], 1'b0};
                    end
                    cnt_d = cnt_q + 7'd1;
                end else begin
                    if ((gate_q == 32'd0) || (dvd_q[63:32] != 32'd0)) begin
                        freq_d = 32'hFFFF_FFFF;
                    end else begin
                        freq_d = dvd_q[31:0];
                    end
                    bin_d = freq_d;
                    bcd_d = 40'd0;
                    cnt_d = 7'd0;
                end
            end
            StBcd: begin
                if (!bcd_done) begin
                    bcd_d = {bcd_adj[38:0], bin_q[31]};
                    bin_d = {bin_q[30:0], 1'b0};
                    cnt_d = cnt_q + 7'd1;
                end else begin
                    ptr_d = 5'd0;
                end
            end
            StSend: begin
                if (tx_ready && !last_byte) ptr_d = ptr_q + 5'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ro_q   <= 1'b0;
            fx_q   <= 32'd0;
            gate_q <= 32'd0;
            dvd_q  <= 64'd0;
            rem_q  <= 33'd0;
            cnt_q  <= 7'd0;
            freq_q <= 32'd0;
            bin_q  <= 32'd0;
            bcd_q  <= 40'd0;
            ptr_q  <= 5'd0;
        end else begin
            ro_q   <= read_over;
            fx_q   <= fx_d;
            gate_q <= gate_d;
            dvd_q  <= dvd_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            freq_q <= freq_d;
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            ptr_q  <= ptr_d;
        end
    end

endmodule

// File: tb/tb_freq_report.sv
// Directed bench for freq_report: expected frame bytes are queued at trigger time and
// popped as the DUT hands bytes over; cycle-exact checks on freq_valid and first byte.
module tb_freq_report;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] read_fx_cnt;
    logic [31:0] read_gate_cnt;
    logic        read_over;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] freq_hz;
    logic        freq_valid;
    logic        busy;

    int          n_cmp = 0;
    int          n_err = 0;
    int          frames = 0;
    logic        chk_idle = 1'b0;
    logic [7:0]  sb [$];

    localparam int ModeNormal = 0;
    localparam int ModeBackpr = 1;
    localparam int ModeHold   = 2;
    localparam int ModeRetrig = 3;
    localparam int ModeReset  = 4;

    freq_report #(.CLK_HZ(50_000_000)) dut (
        .clk           (clk),
        .rst           (rst),
        .read_fx_cnt   (read_fx_cnt),
        .read_gate_cnt (read_gate_cnt),
        .read_over     (read_over),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .freq_hz       (freq_hz),
        .freq_valid    (freq_valid),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [31:0] f);
        string s;
        s = $sformatf("F=%0dHz", f);
        for (int i = 0; i < s.len(); i++) sb.push_back(8'(s[i]));
        sb.push_back(8'h0D);
        sb.push_back(8'h0A);
    endtask

    // Scoreboard: pop and compare on every accepted byte; busy must be low after LF.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (chk_idle) begin
            chk("busy_after_lf", {63'd0, busy}, 64'd0);
            chk("valid_after_lf", {63'd0, tx_valid}, 64'd0);
            chk_idle = 1'b0;
        end
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL extra_byte: got %0h expected none", tx_data);
            end else begin
                exp_b = sb.pop_front();
                chk("tx_byte", {56'd0, tx_data}, {56'd0, exp_b});
                if (exp_b == 8'h0A) begin
                    frames++;
                    chk_idle = 1'b1;
                end
            end
        end
    end

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            n_cmp++;
            n_err++;
            $error("FAIL idle_timeout: busy %b expected 0 within %0d cycles", busy, bound);
        end
        @(negedge clk);
        chk("frame_complete", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_frame(input logic [31:0] fx, input logic [31:0] gate,
                            input logic [31:0] exp_f, input int mode);
        push_frame(exp_f);
        @(posedge clk); #1;
        read_fx_cnt   = fx;
        read_gate_cnt = gate;
        read_over     = 1'b1;
        @(posedge clk); #1;                       // edge k
        if (mode != ModeHold) read_over = 1'b0;
        @(negedge clk);
        chk("busy_at_k", {63'd0, busy}, 64'd1);
        for (int i = 1; i <= 65; i++) begin
            @(posedge clk); #1;
            if (mode == ModeRetrig && i == 10) read_over = 1'b1;
            else if (mode != ModeHold) read_over = 1'b0;
        end
        @(negedge clk);
        chk("fvalid_k65", {63'd0, freq_valid}, 64'd0);
        @(posedge clk);                           // edge k+66
        @(negedge clk);
        chk("fvalid_k66", {63'd0, freq_valid}, 64'd1);
        chk("freq_hz", {32'd0, freq_hz}, {32'd0, exp_f});
        @(posedge clk);
        @(negedge clk);
        chk("fvalid_k67", {63'd0, freq_valid}, 64'd0);
        repeat (31) @(posedge clk);               // edge k+98
        @(negedge clk);
        chk("txv_k98", {63'd0, tx_valid}, 64'd0);
        @(posedge clk);                           // edge k+99
        @(negedge clk);
        chk("txv_k99", {63'd0, tx_valid}, 64'd1);
        chk("txd_k99", {56'd0, tx_data}, 64'h46);
        if (mode == ModeBackpr) begin
            @(posedge clk);
            @(posedge clk); #1;                   // after edge k+101: third byte on the bus
            tx_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("bp_valid", {63'd0, tx_valid}, 64'd1);
                chk("bp_data", {56'd0, tx_data}, 64'h31);
                @(posedge clk);
            end
            #1 tx_ready = 1'b1;
        end
        if (mode == ModeReset) begin
            repeat (3) @(posedge clk);            // fourth byte on the bus
            #1 rst = 1'b1;
            #1;
            chk("rst_txvalid", {63'd0, tx_valid}, 64'd0);
            chk("rst_busy", {63'd0, busy}, 64'd0);
            chk("rst_freq", {32'd0, freq_hz}, 64'd0);
            chk("rst_fvalid", {63'd0, freq_valid}, 64'd0);
            sb.delete();
            @(posedge clk); #1 rst = 1'b0;
        end else begin
            wait_idle(200);
        end
    endtask

    initial begin
        int f0;
        rst           = 1'b1;
        read_fx_cnt   = 32'd0;
        read_gate_cnt = 32'd0;
        read_over     = 1'b0;
        tx_ready      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_txdata", {56'd0, tx_data}, 64'd0);
        chk("reset_txvalid", {63'd0, tx_valid}, 64'd0);
        chk("reset_freq", {32'd0, freq_hz}, 64'd0);
        chk("reset_fvalid", {63'd0, freq_valid}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        do_frame(32'd1000, 32'd50_000_000, 32'd1000, ModeNormal);
        do_frame(32'd1, 32'd3, 32'd16_666_667, ModeNormal);
        do_frame(32'd0, 32'd50_000_000, 32'd0, ModeNormal);
        do_frame(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, ModeNormal);
        do_frame(32'd1234, 32'd0, 32'hFFFF_FFFF, ModeNormal);
        do_frame(32'd1000, 32'd50_000_000, 32'd1000, ModeBackpr);

        f0 = frames;
        do_frame(32'd1000, 32'd50_000_000, 32'd1000, ModeHold);
        repeat (1800) @(posedge clk);
        @(negedge clk);
        chk("hold_one_frame", 64'(frames - f0), 64'd1);
        chk("hold_idle", {63'd0, busy}, 64'd0);
        @(posedge clk); #1 read_over = 1'b0;
        repeat (3) @(posedge clk);

        f0 = frames;
        do_frame(32'd50, 32'd50_000, 32'd50_000, ModeRetrig);
        repeat (5) @(negedge clk);
        chk("retrig_one_frame", 64'(frames - f0), 64'd1);
        chk("retrig_idle", {63'd0, busy}, 64'd0);

        do_frame(32'd1000, 32'd50_000_000, 32'd1000, ModeReset);
        repeat (3) @(posedge clk);
        f0 = frames;
        do_frame(32'd7, 32'd50_000_000, 32'd7, ModeNormal);
        chk("post_reset_frame", 64'(frames - f0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
